serial_add2_ctrl: RTL and testbench

Sequencer that performs a WIDTH-bit addition by time-multiplexing one external 2-bit ripple adder slice (ports a1,a0,b1,b0,c0 -> c1,s1,s0), two bits per digit, LSB digit first. It holds a carry register between digits and waits SETTLE_CYC clocks per digit so the slice's gate-level outputs settle before capture. A start/done handshake connects it to the surrounding design.

---
 rtl/serial_add2_pkg.sv | 16 +
 rtl/serial_add2_ctrl_settle_timer.sv | 51 +++++
 rtl/serial_add2_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_serial_add2_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add2_pkg.sv
// Shared definitions for the serial two-bit-per-digit adder sequencer.
// Holds the controller state encoding used by the top level.
package serial_add2_pkg;

    // Controller states; encodings are fixed so that debug probes read stable values.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Bits consumed from each operand per digit.
    localparam int DIGIT_BITS = 2;

endpackage

// File: rtl/serial_add2_ctrl_settle_timer.sv
// settle_timer: loadable down-counter with a registered zero flag.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset (count cleared, zero=1)
//   load     load load_val (has priority over dec)
//   load_val value loaded on load
//   dec      decrement by one; saturates at zero
//   zero     high while the registered count is zero
module settle_timer
    import serial_add2_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          zero_r;

    // Next count: load wins over decrement, decrement never wraps below zero.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_val;
        end else if (dec && (count_r != {CW{1'b0}})) begin
            count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register; the zero flag is registered from the next count so it tracks count_r exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            zero_r  <= 1'b1;
        end else begin
            count_r <= count_next_s;
            zero_r  <= (count_next_s == {CW{1'b0}});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/serial_add2_ctrl.sv
// serial_add2_ctrl: performs a WIDTH-bit add by reusing one external 2-bit
// ripple slice, LSB digit first, with SETTLE_CYC clocks of settling per digit.
// Ports:
//   clk, rst                         clock and async active-high reset
//   start, a_in, b_in, cin           request and operands (latched in IDLE)
//   add_a1..add_c0                   drives to the external slice
//   add_c1, add_s1, add_s0           slice carry/sum returned
//   sum, cout                        result, held until the next accepted start
//   busy                             high while digits are being processed
//   done                             one-cycle completion pulse
module serial_add2_ctrl
    import serial_add2_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             add_a1,
    output logic             add_a0,
    output logic             add_b1,
    output logic             add_b0,
    output logic             add_c0,
    input  logic             add_c1,
    input  logic             add_s1,
    input  logic             add_s0,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int DIGITS = WIDTH / DIGIT_BITS;
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(SETTLE_CYC - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic [DW-1:0]    digit_r;
    logic             busy_r;
    logic             done_r;
    logic             timer_load_s;
    logic             timer_dec_s;
    logic             timer_zero_s;
    logic             last_digit_s;
    logic             drive_en_s;
    logic [WIDTH+1:0] sum_cat_s;

    settle_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load_s),
        .load_val (WAIT_LOAD),
        .dec      (timer_dec_s),
        .zero     (timer_zero_s)
    );

    assign last_digit_s = (digit_r == LAST_DIGIT);
    // New digit enters at the top; shifting the concatenation keeps this valid for WIDTH=2.
    assign sum_cat_s    = {add_s1, add_s0, sum_r} >> 2'd2;

    // Next-state and timer control.
    always_comb begin
        next_state_s = state_r;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_SETTLE;
                    timer_load_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero_s) begin
                    next_state_s = ST_CAPTURE;
                end else begin
                    timer_dec_s  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (last_digit_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SETTLE;
                    timer_load_s = 1'b1;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus busy/done, registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_SETTLE) || (next_state_s == ST_CAPTURE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Operand shift registers, carry, digit counter and result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            digit_r <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a_in;
                        b_r     <= b_in;
                        carry_r <= cin;
                        sum_r   <= {WIDTH{1'b0}};
                        cout_r  <= 1'b0;
                        digit_r <= {DW{1'b0}};
                    end
                end
                ST_CAPTURE: begin
                    sum_r   <= sum_cat_s[WIDTH-1:0];
                    carry_r <= add_c1;
                    a_r     <= a_r >> 2'd2;
                    b_r     <= b_r >> 2'd2;
                    if (last_digit_s) begin
                        cout_r  <= add_c1;
                    end else begin
                        digit_r <= digit_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slice drives come straight from registers and are forced low outside SETTLE/CAPTURE.
    always_comb begin
        drive_en_s = (state_r == ST_SETTLE) || (state_r == ST_CAPTURE);
        add_a1 = 1'b0;
        add_a0 = 1'b0;
        add_b1 = 1'b0;
        add_b0 = 1'b0;
        add_c0 = 1'b0;
        if (drive_en_s) begin
            add_a1 = a_r[1];
            add_a0 = a_r[0];
            add_b1 = b_r[1];
            add_b0 = b_r[0];
            add_c0 = carry_r;
        end else begin
            add_a1 = 1'b0;
            add_a0 = 1'b0;
            add_b1 = 1'b0;
            add_b0 = 1'b0;
            add_c0 = 1'b0;
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_add2_ctrl.sv
// Directed bench for serial_add2_ctrl: an 8-bit/SETTLE_CYC=2 instance and a
// 4-bit/SETTLE_CYC=1 instance, each wired to a gate-level 2-bit ripple slice.
// Cycle numbering: start is presented in cycle 0; cycle k is the cycle after
// the k-th rising edge following that, so the accepting edge ends cycle 0.
module tb_serial_add2_ctrl;

    logic       clk;
    logic       rst;
    int         checks;
    int         errors;

    // 8-bit instance signals
    logic       start;
    logic [7:0] a_in, b_in;
    logic       cin;
    wire        add_a1, add_a0, add_b1, add_b0, add_c0;
    wire        add_c1, add_s1, add_s0;
    logic [7:0] sum;
    logic       cout, busy, done;

    // 4-bit instance signals
    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    wire        q_a1, q_a0, q_b1, q_b0, q_c0;
    wire        q_c1, q_s1, q_s0;
    logic [3:0] sum4;
    logic       cout4, busy4, done4;

    serial_add2_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .add_a1(add_a1), .add_a0(add_a0), .add_b1(add_b1), .add_b0(add_b0), .add_c0(add_c0),
        .add_c1(add_c1), .add_s1(add_s1), .add_s0(add_s0),
        .sum(sum), .cout(cout), .busy(busy), .done(done)
    );

    serial_add2_ctrl #(.WIDTH(4), .SETTLE_CYC(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
        .add_a1(q_a1), .add_a0(q_a0), .add_b1(q_b1), .add_b0(q_b0), .add_c0(q_c0),
        .add_c1(q_c1), .add_s1(q_s1), .add_s0(q_s0),
        .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
    );

    // Gate-level 2-bit ripple slice for the 8-bit instance
    wire p0, g0, t0, cm, p1, g1, t1;
    xor (p0, add_a0, add_b0);
    xor (add_s0, p0, add_c0);
    and (g0, add_a0, add_b0);
    and (t0, p0, add_c0);
    or  (cm, g0, t0);
    xor (p1, add_a1, add_b1);
    xor (add_s1, p1, cm);
    and (g1, add_a1, add_b1);
    and (t1, p1, cm);
    or  (add_c1, g1, t1);

    // Gate-level 2-bit ripple slice for the 4-bit instance
    wire r0, h0, u0, rm, r1, h1, u1;
    xor (r0, q_a0, q_b0);
    xor (q_s0, r0, q_c0);
    and (h0, q_a0, q_b0);
    and (u0, r0, q_c0);
    or  (rm, h0, u0);
    xor (r1, q_a1, q_b1);
    xor (q_s1, r1, rm);
    and (h1, q_a1, q_b1);
    and (u1, r1, rm);
    or  (q_c1, h1, u1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an 8-bit request in the current cycle (cycle 0).
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
    endtask

    // Runs max_k cycles after launch8, dropping start after acceptance and
    // optionally re-pulsing start (with different operands) at restart_at.
    task automatic watch8(input int max_k, input int restart_at,
                          output int done_at, output int busy_cnt,
                          output int done_cnt, output int c0_cnt);
        done_at = 0; busy_cnt = 0; done_cnt = 0; c0_cnt = 0;
        for (int k = 1; k <= max_k; k++) begin
            tick();
            if (busy) busy_cnt++;
            if (busy && add_c0) c0_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (k == 1) start = 1'b0;
            if (restart_at != 0 && k == restart_at) begin
                start = 1'b1; a_in = 8'h77; b_in = 8'h33; cin = 1'b1;
            end
            if (restart_at != 0 && k == restart_at + 1) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00; cin = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        tick(); tick();
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
        checks++; if ({add_a1, add_a0, add_b1, add_b0, add_c0} !== 5'b00000) begin errors++;
            $display("FAIL reset_drives got %b want 00000", {add_a1, add_a0, add_b1, add_b0, add_c0}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int da, bc, dc, cc;
        launch8(8'hB7, 8'h5C, 1'b0);
        watch8(20, 0, da, bc, dc, cc);
        checks++; if (da !== 13) begin errors++; $display("FAIL basic_latency got %0d want 13", da); end
        checks++; if (bc !== 12) begin errors++; $display("FAIL basic_busy_cycles got %0d want 12", bc); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", dc); end
        checks++; if (sum !== 8'h13) begin errors++; $display("FAIL basic_sum got %h want 13", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL basic_cout got %b want 1", cout); end
        checks++; if ({add_a1, add_a0, add_b1, add_b0, add_c0} !== 5'b00000) begin errors++;
            $display("FAIL idle_drives got %b want 00000", {add_a1, add_a0, add_b1, add_b0, add_c0}); end
    endtask

    task automatic test_carry_chain();
        int da, bc, dc, cc;
        launch8(8'hFF, 8'h00, 1'b1);
        watch8(20, 0, da, bc, dc, cc);
        checks++; if (cc !== 12) begin errors++; $display("FAIL chain_c0_high got %0d want 12", cc); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL chain_sum got %h want 00", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL chain_cout got %b want 1", cout); end
    endtask

    task automatic test_ignored_start();
        int da, bc, dc, cc;
        launch8(8'h01, 8'h01, 1'b0);
        watch8(20, 4, da, bc, dc, cc);
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_done_pulses got %0d want 1", dc); end
        checks++; if (da !== 13) begin errors++; $display("FAIL ignore_latency got %0d want 13", da); end
        checks++; if (sum !== 8'h02) begin errors++; $display("FAIL ignore_sum got %h want 02", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ignore_cout got %b want 0", cout); end
    endtask

    task automatic test_reset_mid();
        int da, bc, dc, cc;
        int late_done;
        launch8(8'hB7, 8'h5C, 1'b0);
        // Digit d is captured in cycle 3d+3; cycle 9 is CAPTURE of digit 2.
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        checks++; if (sum !== 8'h30) begin errors++; $display("FAIL mid_partial_sum got %h want 30", sum); end
        rst = 1'b1;
        #1;
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL mid_rst_sum got %h want 00", sum); end
        checks++; if ({cout, busy, done} !== 3'b000) begin errors++;
            $display("FAIL mid_rst_flags got %b want 000", {cout, busy, done}); end
        checks++; if ({add_a1, add_a0, add_b1, add_b0, add_c0} !== 5'b00000) begin errors++;
            $display("FAIL mid_rst_drives got %b want 00000", {add_a1, add_a0, add_b1, add_b0, add_c0}); end
        tick();
        rst = 1'b0;
        late_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) late_done++;
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", late_done); end
        launch8(8'h0A, 8'h05, 1'b0);
        watch8(20, 0, da, bc, dc, cc);
        checks++; if (sum !== 8'h0F) begin errors++; $display("FAIL after_rst_sum got %h want 0f", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL after_rst_cout got %b want 0", cout); end
    endtask

    task automatic test_small();
        int da, dc;
        da = 0; dc = 0;
        a4 = 4'hA; b4 = 4'hA; cin4 = 1'b0; start4 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (done4) begin
                dc++;
                if (da == 0) da = k;
            end
            if (k == 1) start4 = 1'b0;
        end
        checks++; if (da !== 5) begin errors++; $display("FAIL small_latency got %0d want 5", da); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL small_done_pulses got %0d want 1", dc); end
        checks++; if (sum4 !== 4'h4) begin errors++; $display("FAIL small_sum got %h want 4", sum4); end
        checks++; if (cout4 !== 1'b1) begin errors++; $display("FAIL small_cout got %b want 1", cout4); end
    endtask

    task automatic test_back_to_back();
        int last_at, nd;
        last_at = 0; nd = 0;
        launch8(8'h10, 8'h20, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done) begin
                nd++;
                checks++; if (sum !== 8'h30) begin errors++; $display("FAIL b2b_sum got %h want 30 at cycle %0d", sum, k); end
                if (last_at == 0) begin
                    checks++; if (k !== 13) begin errors++; $display("FAIL b2b_first got %0d want 13", k); end
                end else begin
                    checks++; if (k - last_at !== 14) begin errors++; $display("FAIL b2b_interval got %0d want 14", k - last_at); end
                end
                last_at = k;
            end
        end
        checks++; if (nd !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", nd); end
        start = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_drain got %b want 00", {busy, done}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_ignored_start();
        test_reset_mid();
        test_small();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
